gcd_initiator: RTL and testbench
================================

Name: gcd_initiator

Overview:
Front-end controller that accepts GCD operand pairs on a valid/ready request channel and drives one gcd compute core through its start/done interface. It captures the core result and presents it on a valid/ready response channel. It sits between the command source and the core, serialising requests one at a time. A watchdog aborts jobs that run too long.

Parameters:
WIDTH, 8, operand/result width; must match core.
TIMEOUT, 1023, max WAIT cycles before abort; 1..2^CNT_W-1.
CNT_W, 10, width of watchdog counter.

Ports:
clk  in  1  clock.
rst  in  1  reset; synchronous, active-low (0 = reset).
req_valid  in  1  request present.
req_ready  out  1  initiator can accept request.
req_a  in  WIDTH  operand a.
req_b  in  WIDTH  operand b.
core_rst  out  1  core restart/load; active-high; core loads core_a/core_b while high.
core_a  out  WIDTH  operand a to core.
core_b  out  WIDTH  operand b to core.
core_ret  in  WIDTH  core result.
core_done  in  1  core result valid; level, held until next core_rst.
rsp_valid  out  1  response present.
rsp_ready  in  1  consumer accepts response.
rsp_ret  out  WIDTH  gcd result (0 on error).
rsp_err  out  1  job aborted by watchdog.

Behaviour:
- All outputs registered except req_ready, which is decoded from state only. No combinational path from any input to any output.
- Reset (rst=0 at posedge):
  - state=IDLE.
  - core_rst=1, core_a=core_b=0.
  - rsp_valid=0, rsp_ret=0, rsp_err=0.
  - watchdog=0.
- Reset mid-job discards the job silently, with no response. The core is parked because core_rst=1.
- States are one-hot: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - req_ready=1, core_rst=1.
  - On req_valid: capture req_a/req_b into core_a/core_b and go to LAUNCH.
- LAUNCH (exactly 1 cycle):
  - req_ready=0, core_rst stays 1 with new operands stable, so the core loads them.
  - Next: WAIT, core_rst<=0, watchdog<=0.
  - core_done is ignored here, because it may be stale from the previous job.
- WAIT:
  - core_a/core_b held stable; the core re-samples them in its START state.
  - watchdog increments every cycle.
  - If core_done=1: rsp_ret<=core_ret, rsp_err<=0, rsp_valid<=1, core_rst<=1, go to RESP.
  - Else if watchdog==TIMEOUT-1: rsp_ret<=0, rsp_err<=1, rsp_valid<=1, core_rst<=1, go to RESP.
  - If core_done and timeout occur in the same cycle, core_done wins and the response is non-error.
- RESP:
  - rsp_valid=1 with rsp_ret/rsp_err stable until rsp_ready=1.
  - On handshake: rsp_valid<=0 and go to IDLE.
  - req_ready=0 throughout, so there is no request/response overlap. The next request is accepted at the earliest one cycle after the response handshake.
- Overhead beyond core compute time: 1 cycle for request capture, 1 cycle LAUNCH, 1 cycle to register the response.
- Operand edge cases are passed through unchanged; the core defines the results:
  - gcd(a,0)=a.
  - gcd(0,0)=0.
  - gcd(0,b)=b.
  - a<b is legal.
- Back-pressure: rsp_ready may stay low indefinitely. No state is lost and the watchdog is not running in RESP.

Optional Feature:
GCD_INITIATOR_STATS_EN
- Defined: adds outputs stat_done[15:0] and stat_err[15:0], reset to 0.
  - stat_done increments on each non-error response handshake.
  - stat_err increments on each error response handshake.
  - Both saturate at 16'hFFFF.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Basic job: reset, send a=12, b=8 with rsp_ready=1 -> one response, rsp_ret=4, rsp_err=0; req_ready low from the cycle after acceptance until after the response handshake.
- Zero operands: sequence (0,0), (9,0), (0,7) -> rsp_ret 0, 9, 7, all rsp_err=0; core_rst pulses high once per job.
- Swap and coprime cases: (8,12) -> 4; (255,254) -> 1; (96,255) -> 3; checked against a reference model.
- Back-pressure: hold rsp_ready=0 for 20 cycles after rsp_valid -> rsp_valid and rsp_ret=4 stable throughout, req_ready=0, no new request consumed; release -> single handshake, then IDLE.
- Watchdog: TIMEOUT=16, core model with core_done stuck 0 -> rsp_valid after exactly 16 WAIT cycles with rsp_err=1, rsp_ret=0; next job (12,8) with a good core returns 4; with STATS_EN, stat_err=1 and stat_done=1.
- Reset mid-job: assert rst=0 during WAIT -> no response, core_rst=1, req_ready=1 after reset releases; a following job (12,8) returns 4.

Source files
------------

// File: rtl/gcd_initiator_if.sv
// rtl/gcd_initiator_if.sv - request, core and response signal bundle for gcd_initiator
interface gcd_initiator_if #(
    parameter int WIDTH = 8
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             core_rst;
    logic [WIDTH-1:0] core_a;
    logic [WIDTH-1:0] core_b;
    logic [WIDTH-1:0] core_ret;
    logic             core_done;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_ret;
    logic             rsp_err;

    // Initiator side: drives the core and the response channel.
    modport master (
        input  req_valid, req_a, req_b, core_ret, core_done, rsp_ready,
        output req_ready, core_rst, core_a, core_b, rsp_valid, rsp_ret, rsp_err
    );

    // Environment side: command source, gcd core and response consumer.
    modport slave (
        output req_valid, req_a, req_b, core_ret, core_done, rsp_ready,
        input  req_ready, core_rst, core_a, core_b, rsp_valid, rsp_ret, rsp_err
    );
endinterface

// File: rtl/gcd_initiator.sv
// rtl/gcd_initiator.sv - serialising front-end for one gcd core with watchdog (option: GCD_INITIATOR_STATS_EN)
module gcd_initiator #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 1023,
    parameter int CNT_W   = 10
) (
    input  logic            clk,
    input  logic            rst,
    gcd_initiator_if.master bus
`ifdef GCD_INITIATOR_STATS_EN
    ,
    output logic [15:0]     stat_done,
    output logic [15:0]     stat_err
`endif
);
    localparam logic [3:0] S_IDLE   = 4'b0001;
    localparam logic [3:0] S_LAUNCH = 4'b0010;
    localparam logic [3:0] S_WAIT   = 4'b0100;
    localparam logic [3:0] S_RESP   = 4'b1000;

    // Last watchdog value still allowed in WAIT before the job is aborted.
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

    logic [3:0]       state_q, state_d;
    logic             core_rst_q, core_rst_d;
    logic [WIDTH-1:0] core_a_q, core_a_d;
    logic [WIDTH-1:0] core_b_q, core_b_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_ret_q, rsp_ret_d;
    logic             rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0] wd_q, wd_d;

    // Next-state decode; core_done is only looked at in WAIT since it may be stale in LAUNCH.
    always_comb begin
        state_d     = state_q;
        core_rst_d  = core_rst_q;
        core_a_d    = core_a_q;
        core_b_d    = core_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_ret_d   = rsp_ret_q;
        rsp_err_d   = rsp_err_q;
        wd_d        = wd_q;
        case (state_q)
            S_IDLE: begin
                core_rst_d = 1'b1;
                if (bus.req_valid) begin
                    core_a_d = bus.req_a;
                    core_b_d = bus.req_b;
                    state_d  = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                core_rst_d = 1'b0;
                wd_d       = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                wd_d = wd_q + CNT_W'(1);
                if (bus.core_done) begin
                    rsp_ret_d   = bus.core_ret;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    core_rst_d  = 1'b1;
                    state_d     = S_RESP;
                end else if (wd_q == WD_LAST) begin
                    rsp_ret_d   = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    core_rst_d  = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                core_rst_d  = 1'b1;
                rsp_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset parks the core and drops any job in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            core_rst_q  <= 1'b1;
            core_a_q    <= '0;
            core_b_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_ret_q   <= '0;
            rsp_err_q   <= 1'b0;
            wd_q        <= '0;
        end else begin
            state_q     <= state_d;
            core_rst_q  <= core_rst_d;
            core_a_q    <= core_a_d;
            core_b_q    <= core_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_ret_q   <= rsp_ret_d;
            rsp_err_q   <= rsp_err_d;
            wd_q        <= wd_d;
        end
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.core_rst  = core_rst_q;
    assign bus.core_a    = core_a_q;
    assign bus.core_b    = core_b_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_ret   = rsp_ret_q;
    assign bus.rsp_err   = rsp_err_q;

`ifdef GCD_INITIATOR_STATS_EN
    logic        rsp_hs;
    logic [15:0] stat_done_q, stat_err_q;

    assign rsp_hs = (state_q == S_RESP) && bus.rsp_ready;

    // Saturating counts of completed and aborted jobs, bumped on the response handshake.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_done_q <= '0;
            stat_err_q  <= '0;
        end else if (rsp_hs) begin
            if (rsp_err_q) begin
                if (stat_err_q != 16'hFFFF) stat_err_q <= stat_err_q + 16'd1;
            end else begin
                if (stat_done_q != 16'hFFFF) stat_done_q <= stat_done_q + 16'd1;
            end
        end
    end

    assign stat_done = stat_done_q;
    assign stat_err  = stat_err_q;
`endif
endmodule

// File: tb/tb_gcd_initiator.sv
// tb/tb_gcd_initiator.sv - randomized self-checking bench for gcd_initiator with behavioural core
module tb_gcd_initiator;
    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    gcd_initiator_if #(.WIDTH(WIDTH)) bus ();

`ifdef GCD_INITIATOR_STATS_EN
    logic [15:0] stat_done, stat_err;
`endif

    gcd_initiator #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .CNT_W(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef GCD_INITIATOR_STATS_EN
        ,
        .stat_done (stat_done),
        .stat_err  (stat_err)
`endif
    );

    int checks   = 0;
    int failures = 0;
    int exp_done = 0;
    int exp_err  = 0;

    int core_lat   = 1;
    bit core_stuck = 1'b0;
    int core_cnt   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Core result: repeated subtraction, independent of the Euclid reference.
    function automatic logic [7:0] gcd_sub(input logic [7:0] a, input logic [7:0] b);
        int x, y;
        x = a; y = b;
        if (x == 0) return 8'(y);
        if (y == 0) return 8'(x);
        while (x != y) begin
            if (x > y) x = x - y;
            else       y = y - x;
        end
        return 8'(x);
    endfunction

    function automatic logic [7:0] ref_gcd(input logic [7:0] a, input logic [7:0] b);
        int x, y, t;
        x = a; y = b;
        while (y != 0) begin
            t = x % y; x = y; y = t;
        end
        return 8'(x);
    endfunction

    // Behavioural core: loads while core_rst is high, raises a held done core_lat cycles after release.
    always @(posedge clk) begin
        if (bus.core_rst) begin
            core_cnt      <= 0;
            bus.core_done <= 1'b0;
            bus.core_ret  <= gcd_sub(bus.core_a, bus.core_b);
        end else begin
            core_cnt <= core_cnt + 1;
            if (!core_stuck && (core_cnt + 1 >= core_lat)) bus.core_done <= 1'b1;
        end
    end

    task automatic do_job(input logic [7:0] a, input logic [7:0] b, input int lat,
                          input bit stuck, input int hold);
        logic [7:0] er;
        bit ee, seen, rr_bad, op_bad, stab_bad;
        int low;
        ee = stuck || (lat > TIMEOUT - 1);
        er = ee ? 8'd0 : ref_gcd(a, b);
        core_lat = lat; core_stuck = stuck;
        @(negedge clk);
        check("idle_req_ready", bus.req_ready, 1);
        bus.req_valid = 1'b1; bus.req_a = a; bus.req_b = b;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("launch_req_ready", bus.req_ready, 0);
        check("launch_core_a", bus.core_a, a);
        check("launch_core_b", bus.core_b, b);
        check("launch_core_rst", bus.core_rst, 1);
        low = 0; seen = 0; rr_bad = 0; op_bad = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                seen = 1;
                break;
            end
            if (!bus.core_rst) low++;
            if (bus.req_ready) rr_bad = 1;
            if (bus.core_a != a || bus.core_b != b) op_bad = 1;
        end
        check("rsp_seen", seen, 1);
        check("wait_cycles", low, ee ? TIMEOUT : lat + 1);
        check("wait_req_ready_low", rr_bad, 0);
        check("wait_operands_stable", op_bad, 0);
        check("rsp_ret", bus.rsp_ret, er);
        check("rsp_err", bus.rsp_err, ee);
        check("resp_core_rst", bus.core_rst, 1);
        stab_bad = 0;
        if (hold > 0) begin
            bus.req_valid = 1'b1; bus.req_a = ~a; bus.req_b = ~b;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (!bus.rsp_valid || bus.rsp_ret != er || bus.rsp_err != ee || bus.req_ready)
                    stab_bad = 1;
            end
            check("hold_stable", stab_bad, 0);
            check("hold_no_capture", {bus.core_a, bus.core_b}, {a, b});
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        if (ee) exp_err++; else exp_done++;
        check("post_hs_rsp_valid", bus.rsp_valid, 0);
        check("post_hs_req_ready", bus.req_ready, 1);
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_core_rst", bus.core_rst, 1);
        check("rst_core_ab", {bus.core_a, bus.core_b}, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_ret", bus.rsp_ret, 0);
        check("rst_rsp_err", bus.rsp_err, 0);
        check("rst_req_ready", bus.req_ready, 1);
        rst = 1'b1;

        do_job(8'd12, 8'd8, 3, 0, 0);
        do_job(8'd0, 8'd0, 2, 0, 0);
        do_job(8'd9, 8'd0, 1, 0, 0);
        do_job(8'd0, 8'd7, 4, 0, 0);
        do_job(8'd8, 8'd12, 5, 0, 1);
        do_job(8'd255, 8'd254, 7, 0, 0);
        do_job(8'd96, 8'd255, 2, 0, 2);
        do_job(8'd12, 8'd8, 5, 0, 20);
        do_job(8'd5, 8'd10, 1, 1, 0);
        do_job(8'd12, 8'd8, 6, 0, 0);
        do_job(8'd30, 8'd18, 15, 0, 0);
        do_job(8'd30, 8'd18, 16, 0, 0);

        // Reset in the middle of a stuck job: nothing comes out and the block is idle again.
        core_lat = 1; core_stuck = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_a = 8'd21; bus.req_b = 8'd14;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_core_rst", bus.core_rst, 1);
        check("midrst_rsp_valid", bus.rsp_valid, 0);
        check("midrst_req_ready", bus.req_ready, 1);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("postrst_req_ready", bus.req_ready, 1);
        check("postrst_rsp_valid", bus.rsp_valid, 0);
`ifdef GCD_INITIATOR_STATS_EN
        check("postrst_stat_done", stat_done, 0);
        check("postrst_stat_err", stat_err, 0);
`endif
        exp_done = 0; exp_err = 0;
        do_job(8'd12, 8'd8, 4, 0, 0);
        do_job(8'd1, 8'd2, 1, 1, 0);

        for (int k = 0; k < 24; k++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 4) == 0) rb = 8'd0;
            do_job(ra, rb, int'($urandom_range(1, 17)), ($urandom_range(0, 9) == 0),
                   int'($urandom_range(0, 3)));
        end

`ifdef GCD_INITIATOR_STATS_EN
        check("stat_done", stat_done, exp_done);
        check("stat_err", stat_err, exp_err);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
